pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB). It drives the enable and flush inputs of the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It resolves three cases: load-use hazards, taken branches resolved in EXE, and multi-cycle SRAM accesses in MEM. A watchdog halts the core on a hung memory access, and a saturating stall-cycle counter feeds performance debug.

Parameters:
FWD_EN, 1, 1 = forwarding unit present, stall only on load-use; 0 = stall on any RAW hit against EXE or MEM.
MEM_TIMEOUT, 64, max consecutive wait cycles for one memory access before halting (must be ≥2).
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
id_src1  in  5  ID-stage source register 1.
id_src2  in  5  ID-stage source register 2.
id_two_src  in  1  ID instruction reads src2 (R-type or store).
exe_dest  in  5  destination register of the EXE-stage instruction.
exe_wb_en  in  1  EXE instruction writes back.
exe_mem_read  in  1  EXE instruction is a load.
exe_br_taken  in  1  branch resolved taken in EXE.
mem_dest  in  5  MEM-stage destination register.
mem_wb_en  in  1  MEM instruction writes back.
mem_req  in  1  MEM-stage instruction accesses SRAM (load or store).
mem_ready  in  1  SRAM completes the access this cycle.
pc_en  out  1  PC load enable.
if_id_en  out  1  IF/ID register enable.
if_id_flush  out  1  IF/ID register loads a NOP.
id_exe_en  out  1  ID/EXE register enable.
id_exe_flush  out  1  ID/EXE register loads a bubble (all control fields 0).
exe_mem_en  out  1  EXE/MEM register enable.
mem_wb_flush  out  1  MEM/WB register loads a bubble.
halted  out  1  core halted by memory timeout (sticky).
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.

Behaviour:
- States: RUN, ERR. Reset (rst=0, async) forces RUN, wait_cnt=0, stall_cnt=0, halted=0. While rst=0, all *_en=0 and all *_flush=1.
- Register 0 never creates a hazard. Any comparison with dest==0 is a miss.
- hit_exe = exe_wb_en & exe_dest!=0 & (exe_dest==id_src1 | (id_two_src & exe_dest==id_src2)). hit_mem is the same with the mem_* inputs.
- raw_stall = FWD_EN ? (hit_exe & exe_mem_read) : (hit_exe | hit_mem).
- mem_freeze = mem_req & ~mem_ready (state RUN).
- All outputs are combinational on state and inputs (Mealy, zero latency). Priority, highest first, in RUN:
  1. mem_freeze: pc_en, if_id_en, id_exe_en, exe_mem_en = 0; mem_wb_flush=1; other flushes 0. A pending branch or RAW is held, because EXE and ID are frozen.
  2. exe_br_taken: all enables 1; if_id_flush=1; id_exe_flush=1. Overrides raw_stall.
  3. raw_stall: pc_en=0, if_id_en=0, id_exe_flush=1; id_exe_en=1, exe_mem_en=1.
  4. Otherwise: all enables 1, all flushes 0.
- wait_cnt (width clog2(MEM_TIMEOUT)+1):
  - Increments each mem_freeze cycle.
  - Clears on any cycle with mem_freeze=0.
  - If mem_freeze and wait_cnt==MEM_TIMEOUT-1, the next state is ERR.
- ERR: halted=1, all enables 0, all flushes 0. Stays in ERR until rst; mem_ready is ignored.
- stall_cnt increments on every posedge where pc_en was 0 in RUN, and saturates at all-ones. It does not count in ERR.
- mem_ready arriving in the same cycle as mem_req is a single-cycle access with no freeze.
- Reset asserted mid-freeze clears wait_cnt, returns to RUN, and releases the freeze immediately.

Test Plan:
- Load-use: exe_mem_read=1, exe_wb_en=1, exe_dest=5, id_src1=5 → pc_en=0, if_id_en=0, id_exe_flush=1 for 1 cycle. With exe_dest=0 → no stall.
- FWD_EN=0: mem_wb_en=1, mem_dest=7, id_two_src=1, id_src2=7 → stall. Same stimulus with id_two_src=0 → no stall.
- Branch vs load-use in the same cycle: exe_br_taken=1 plus a RAW hit → all en=1, if_id_flush=1, id_exe_flush=1, no stall; stall_cnt unchanged.
- SRAM wait: mem_req=1, mem_ready=0 for 4 cycles with exe_br_taken=1 → full freeze and mem_wb_flush=1 for 4 cycles. On the ready cycle, the branch flush fires; stall_cnt=4.
- Timeout, MEM_TIMEOUT=8: mem_ready held 0 → halted=1 after the 8th wait cycle; enables stay 0 even after mem_ready=1; rst low → halted=0, stall_cnt=0.
- Saturation, CNT_W=4: 20 stall cycles → stall_cnt=15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and RAW stalls, taken-branch
// flushes, SRAM wait freezes, a memory watchdog that halts the core, and a stall counter.
module pipeline_hazard_ctrl #(
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_two_src,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic             exe_br_taken,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_exe_en,
    output logic             id_exe_flush,
    output logic             exe_mem_en,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic {RUN, ERR} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic hit_exe, hit_mem, raw_stall, mem_freeze, wait_expired;

    // Register 0 is hardwired, so a zero destination never matches.
    assign hit_exe = exe_wb_en && (exe_dest != 5'd0) &&
                     ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
    assign hit_mem = mem_wb_en && (mem_dest != 5'd0) &&
                     ((mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2)));

    assign raw_stall    = (FWD_EN != 0) ? (hit_exe && exe_mem_read) : (hit_exe || hit_mem);
    assign mem_freeze   = (state_q == RUN) && mem_req && !mem_ready;
    assign wait_expired = (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1));

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_exe_en    = 1'b1;
        id_exe_flush = 1'b0;
        exe_mem_en   = 1'b1;
        mem_wb_flush = 1'b0;
        if (!rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_exe_en    = 1'b0;
            id_exe_flush = 1'b1;
            exe_mem_en   = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (state_q == ERR) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_exe_en  = 1'b0;
            exe_mem_en = 1'b0;
        end else if (mem_freeze) begin
            // Front of the pipe holds still, so any pending branch/RAW survives the freeze.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_en    = 1'b0;
            exe_mem_en   = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (exe_br_taken) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (raw_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_flush = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        stall_cnt_d = stall_cnt_q;
        if (state_q == RUN) begin
            if (mem_freeze) begin
                if (wait_expired) state_d = ERR;
                else              wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
            if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign halted    = (state_q == ERR);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controllers (forwarding on/off) share stimulus; expected
// control vectors are queued per cycle and checked by an independent monitor.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_two_src, exe_wb_en, exe_mem_read, exe_br_taken;
    logic       mem_wb_en, mem_req, mem_ready;

    logic       pc_en_a, if_id_en_a, if_id_flush_a, id_exe_en_a, id_exe_flush_a, exe_mem_en_a, mem_wb_flush_a, halted_a;
    logic       pc_en_b, if_id_en_b, if_id_flush_b, id_exe_en_b, id_exe_flush_b, exe_mem_en_b, mem_wb_flush_b, halted_b;
    logic [3:0] stall_cnt_a, stall_cnt_b;

    pipeline_hazard_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .exe_br_taken(exe_br_taken), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en_a), .if_id_en(if_id_en_a), .if_id_flush(if_id_flush_a),
        .id_exe_en(id_exe_en_a), .id_exe_flush(id_exe_flush_a), .exe_mem_en(exe_mem_en_a),
        .mem_wb_flush(mem_wb_flush_a), .halted(halted_a), .stall_cnt(stall_cnt_a)
    );

    pipeline_hazard_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .exe_br_taken(exe_br_taken), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en_b), .if_id_en(if_id_en_b), .if_id_flush(if_id_flush_b),
        .id_exe_en(id_exe_en_b), .id_exe_flush(id_exe_flush_b), .exe_mem_en(exe_mem_en_b),
        .mem_wb_flush(mem_wb_flush_b), .halted(halted_b), .stall_cnt(stall_cnt_b)
    );

    // {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush, exe_mem_en, mem_wb_flush}
    localparam logic [6:0] RST = 7'b0010101;
    localparam logic [6:0] NRM = 7'b1101010;
    localparam logic [6:0] STL = 7'b0001110;
    localparam logic [6:0] BR  = 7'b1111110;
    localparam logic [6:0] FRZ = 7'b0000001;
    localparam logic [6:0] HLT = 7'b0000000;

    typedef struct {
        string      nm;
        logic [6:0] ea, eb;
        logic       eh;
        logic [3:0] ca, cb;
    } exp_t;

    exp_t q[$];
    int n_pass = 0, n_total = 0;
    logic [3:0] cnt_a, cnt_b;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.nm, ".ctl_a"}, {pc_en_a, if_id_en_a, if_id_flush_a, id_exe_en_a,
                                     id_exe_flush_a, exe_mem_en_a, mem_wb_flush_a}, e.ea);
            check({e.nm, ".ctl_b"}, {pc_en_b, if_id_en_b, if_id_flush_b, id_exe_en_b,
                                     id_exe_flush_b, exe_mem_en_b, mem_wb_flush_b}, e.eb);
            check({e.nm, ".halt_a"}, halted_a, e.eh);
            check({e.nm, ".halt_b"}, halted_b, e.eh);
            check({e.nm, ".cnt_a"}, stall_cnt_a, e.ca);
            check({e.nm, ".cnt_b"}, stall_cnt_b, e.cb);
        end
    end

    task automatic clr();
        id_src1 = 0; id_src2 = 0; id_two_src = 0; exe_dest = 0; exe_wb_en = 0;
        exe_mem_read = 0; exe_br_taken = 0; mem_dest = 0; mem_wb_en = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    // Queue this cycle's expectation, then advance one clock and update the counter model.
    task automatic step(input string nm, input logic [6:0] ea, input logic [6:0] eb, input logic eh);
        exp_t e;
        e.nm = nm; e.ea = ea; e.eb = eb; e.eh = eh; e.ca = cnt_a; e.cb = cnt_b;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (rst && !eh && !ea[6] && cnt_a != 4'hF) cnt_a++;
        if (rst && !eh && !eb[6] && cnt_b != 4'hF) cnt_b++;
    endtask

    task automatic do_reset();
        rst = 0; cnt_a = 0; cnt_b = 0;
        step("reset", RST, RST, 0);
        rst = 1;
    endtask

    initial begin
        clr();
        rst = 0; cnt_a = 0; cnt_b = 0;
        step("por", RST, RST, 0);
        rst = 1;
        step("idle", NRM, NRM, 0);

        exe_mem_read = 1; exe_wb_en = 1; exe_dest = 5; id_src1 = 5;
        step("load_use", STL, STL, 0);
        clr();
        step("after_lu", NRM, NRM, 0);
        exe_mem_read = 1; exe_wb_en = 1; exe_dest = 0; id_src1 = 0;
        step("dest0", NRM, NRM, 0);
        clr(); exe_wb_en = 1; exe_dest = 9; id_two_src = 1; id_src2 = 9; id_src1 = 4;
        step("exe_alu_raw", NRM, STL, 0);
        clr(); mem_wb_en = 1; mem_dest = 7; id_two_src = 1; id_src2 = 7; id_src1 = 3;
        step("mem_raw", NRM, STL, 0);
        id_two_src = 0;
        step("mem_raw_1src", NRM, NRM, 0);
        clr(); exe_br_taken = 1; exe_mem_read = 1; exe_wb_en = 1; exe_dest = 5; id_src1 = 5;
        step("br_vs_lu", BR, BR, 0);

        clr(); do_reset();
        mem_req = 1; exe_br_taken = 1;
        repeat (4) step("sram_wait", FRZ, FRZ, 0);
        mem_ready = 1;
        step("sram_ready", BR, BR, 0);
        clr(); mem_req = 1; mem_ready = 1;
        step("single_cycle", NRM, NRM, 0);

        clr(); mem_req = 1;
        repeat (7) step("wait_a", FRZ, FRZ, 0);
        mem_ready = 1;
        step("wait_done", NRM, NRM, 0);
        mem_ready = 0;
        repeat (7) step("wait_b", FRZ, FRZ, 0);
        clr();
        step("wait_clear", NRM, NRM, 0);

        mem_req = 1;
        repeat (5) step("pre_rst_wait", FRZ, FRZ, 0);
        do_reset();
        repeat (8) step("to_wait", FRZ, FRZ, 0);
        step("to_halt", HLT, HLT, 1);
        mem_ready = 1;
        step("halt_ready", HLT, HLT, 1);
        step("halt_stay", HLT, HLT, 1);
        clr(); do_reset();
        step("post_halt", NRM, NRM, 0);

        exe_mem_read = 1; exe_wb_en = 1; exe_dest = 12; id_two_src = 1; id_src2 = 12;
        repeat (20) step("sat", STL, STL, 0);
        clr();
        step("sat_end", NRM, NRM, 0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        check("drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
